// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and NZP bit positions for alu_multicycle.
package alu_pkg;

    // Opcode presented on the op port (ignored when cmp=1).
    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } alu_op_t;

    // Handshake FSM states of alu_multicycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        RESULT = 2'd2
    } alu_state_t;

    // Bit positions of the compare result within alu_out.
    localparam int unsigned NZP_N = 0;
    localparam int unsigned NZP_Z = 1;
    localparam int unsigned NZP_P = 2;

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative unsigned restoring divider, one quotient bit per cycle.
// The first quotient bit is produced in the start cycle, so done pulses exactly
// DATA_WIDTH cycles after start with the final quotient already registered.
module alu_divider #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] STEPS_AFTER_START = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STEP         = CNT_W'(1);

    logic [DATA_WIDTH-1:0] remainder;
    logic [DATA_WIDTH-1:0] divisor_q;
    logic [CNT_W-1:0]      count;

    logic [DATA_WIDTH-1:0] src_rem;
    logic [DATA_WIDTH-1:0] src_quo;
    logic [DATA_WIDTH-1:0] src_div;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] next_rem;
    logic [DATA_WIDTH-1:0] next_quo;

    // One restoring step: on start it works on fresh operands, otherwise on the registers.
    always_comb begin
        src_rem  = start ? '0       : remainder;
        src_quo  = start ? dividend : quotient;
        src_div  = start ? divisor  : divisor_q;
        shifted  = {src_rem, src_quo[DATA_WIDTH-1]};
        diff     = shifted - {1'b0, src_div};
        next_rem = shifted[DATA_WIDTH-1:0];
        next_quo = {src_quo[DATA_WIDTH-2:0], 1'b0};
        if (!diff[DATA_WIDTH]) begin
            next_rem    = diff[DATA_WIDTH-1:0];
            next_quo[0] = 1'b1;
        end
    end

    // Iteration control: load on start, step while busy, pulse done after the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            remainder <= '0;
            quotient  <= '0;
            divisor_q <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                remainder <= next_rem;
                quotient  <= next_quo;
                divisor_q <= divisor;
                count     <= STEPS_AFTER_START;
                busy      <= 1'b1;
            end else if (busy) begin
                remainder <= next_rem;
                quotient  <= next_quo;
                count     <= count - LAST_STEP;
                if (count == LAST_STEP) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: per-thread ALU with valid/ready handshake. ADD/SUB/MUL/CMP are
// registered in the accept cycle; DIV runs on alu_divider for DATA_WIDTH cycles.
// Build option: define ALU_SIGNED_CMP_EN for a two's-complement CMP (default unsigned).
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic                  cmp,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  div_zero
);

    alu_state_t state;
    alu_op_t    op_sel;
    logic       accept;
    logic       div_start;
    logic       div_busy;
    logic       div_done;
    logic [DATA_WIDTH-1:0]   div_quotient;
    logic [DATA_WIDTH-1:0]   single_result;
    logic [2*DATA_WIDTH-1:0] product;
    logic cmp_gt;
    logic cmp_eq;
    logic cmp_lt;

    assign op_sel    = alu_op_t'(op);
    assign in_ready  = enable & (state == IDLE) & ~reset;
    assign accept    = in_valid & in_ready;
    assign div_start = accept & ~cmp & (op_sel == DIV) & (rt != '0);

    // Magnitude compare taken directly on the operands, not from a subtraction sign.
    always_comb begin
`ifdef ALU_SIGNED_CMP_EN
        cmp_gt = $signed(rs) > $signed(rt);
        cmp_lt = $signed(rs) < $signed(rt);
`else
        cmp_gt = rs > rt;
        cmp_lt = rs < rt;
`endif
        cmp_eq = rs == rt;
    end

    // Result of every op that completes in the accept cycle (DIV by zero yields all ones).
    always_comb begin
        product       = {{DATA_WIDTH{1'b0}}, rs} * {{DATA_WIDTH{1'b0}}, rt};
        single_result = '0;
        if (cmp) begin
            single_result[NZP_N] = cmp_lt;
            single_result[NZP_Z] = cmp_eq;
            single_result[NZP_P] = cmp_gt;
        end else begin
            case (op_sel)
                ADD:     single_result = rs + rt;
                SUB:     single_result = rs - rt;
                MUL:     single_result = product[DATA_WIDTH-1:0];
                default: single_result = '1;
            endcase
        end
    end

    alu_divider #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (rs),
        .divisor  (rt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Handshake FSM with registered result outputs; results hold until out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alu_out   <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_start) begin
                            state <= DIVIDE;
                        end else begin
                            state     <= RESULT;
                            out_valid <= 1'b1;
                            alu_out   <= single_result;
                            div_zero  <= ~cmp & (op_sel == DIV);
                        end
                    end
                end
                DIVIDE: begin
                    if (div_done && !div_busy) begin
                        state     <= RESULT;
                        out_valid <= 1'b1;
                        alu_out   <= div_quotient;
                        div_zero  <= 1'b0;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
